// File: rtl/frv_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frv_mem_pkg
// Description : Shared types and constants for the fetch/load-store memory
//               arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package frv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } state_t;

    // Owner encoding doubles as the bit index into the one-hot select.
    localparam logic c_OWN_I = 1'b0;
    localparam logic c_OWN_D = 1'b1;

    localparam int c_RSP_LATENCY = 1;

endpackage
`default_nettype wire

// File: rtl/frv_mem_arb_prio.sv
`default_nettype none
// ============================================================================
// Module      : frv_mem_arb_prio
// Description : Fixed-priority select between imem and dmem with a
//               starvation override for the losing side.
// Revision    : 1.0 - initial release
// ============================================================================
module frv_mem_arb_prio
    import frv_mem_pkg::*;
#(
    parameter int D_PRIORITY = 1,
    parameter int MAX_BURST  = 4
) (
    input  logic       i_imem_req,
    input  logic       i_dmem_req,
    input  logic [3:0] i_starve_cnt,
    output logic [1:0] o_sel
);

    localparam logic [3:0] c_MAX_BURST = 4'(MAX_BURST);
    localparam logic       c_D_WINS    = (D_PRIORITY != 0);

    logic w_starved;

    assign w_starved = (i_starve_cnt == c_MAX_BURST);

    always_comb begin
        o_sel = 2'b00;
        if (i_imem_req && i_dmem_req) begin
            // A starved loser flips the tie for exactly one grant.
            if (c_D_WINS != w_starved) begin
                o_sel[c_OWN_D] = 1'b1;
            end else begin
                o_sel[c_OWN_I] = 1'b1;
            end
        end else if (i_dmem_req) begin
            o_sel[c_OWN_D] = 1'b1;
        end else if (i_imem_req) begin
            o_sel[c_OWN_I] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/frv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : frv_mem_arbiter
// Description : Shares one req/gnt memory port between instruction fetch and
//               load/store, with request locking and response routing.
// Revision    : 1.0 - initial release
// ============================================================================
module frv_mem_arbiter
    import frv_mem_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int D_PRIORITY = 1,
    parameter int MAX_BURST  = 4
) (
    input  logic            g_clk,
    input  logic            g_reset,

    input  logic            i_req,
    input  logic            i_wen,
    input  logic [3:0]      i_strb,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_addr,
    output logic            i_gnt,
    output logic            i_error,
    output logic [XLEN-1:0] i_rdata,

    input  logic            d_req,
    input  logic            d_wen,
    input  logic [3:0]      d_strb,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [XLEN-1:0] d_addr,
    output logic            d_gnt,
    output logic            d_error,
    output logic [XLEN-1:0] d_rdata,

    output logic            m_req,
    output logic            m_wen,
    output logic [3:0]      m_strb,
    output logic [XLEN-1:0] m_wdata,
    output logic [XLEN-1:0] m_addr,
    input  logic            m_gnt,
    input  logic            m_error,
    input  logic [XLEN-1:0] m_rdata
);

    localparam logic [3:0] c_MAX_BURST = 4'(MAX_BURST);
    localparam logic       c_TIE_WIN   = (D_PRIORITY != 0) ? c_OWN_D : c_OWN_I;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [3:0]               r_starve_cnt;
    logic [c_RSP_LATENCY-1:0] r_rsp_vld;
    logic                     r_rsp_owner;

    logic [1:0] w_prio_sel;
    logic [1:0] w_sel;
    logic       w_xfer;
    logic       w_xfer_owner;
    logic       w_oth_req;
    logic       w_win_gnt;
    logic       w_oth_gnt;
    logic       w_rsp_i;
    logic       w_rsp_d;

    frv_mem_arb_prio #(
        .D_PRIORITY (D_PRIORITY),
        .MAX_BURST  (MAX_BURST)
    ) u_prio (
        .i_imem_req   (i_req),
        .i_dmem_req   (d_req),
        .i_starve_cnt (r_starve_cnt),
        .o_sel        (w_prio_sel)
    );

    // Reset blanks the select so every output reads zero while it is held.
    always_comb begin
        w_sel = 2'b00;
        if (!g_reset) begin
            case (r_state)
                IDLE:    w_sel = w_prio_sel;
                LOCK_I:  w_sel[c_OWN_I] = 1'b1;
                LOCK_D:  w_sel[c_OWN_D] = 1'b1;
                default: w_sel = 2'b00;
            endcase
        end
    end

    always_comb begin
        m_req   = 1'b0;
        m_wen   = 1'b0;
        m_strb  = 4'b0000;
        m_wdata = '0;
        m_addr  = '0;
        if (w_sel[c_OWN_D]) begin
            m_req   = d_req;
            m_wen   = d_wen;
            m_strb  = d_strb;
            m_wdata = d_wdata;
            m_addr  = d_addr;
        end else if (w_sel[c_OWN_I]) begin
            m_req   = i_req;
            m_wen   = i_wen;
            m_strb  = i_strb;
            m_wdata = i_wdata;
            m_addr  = i_addr;
        end
    end

    assign i_gnt        = m_gnt & w_sel[c_OWN_I];
    assign d_gnt        = m_gnt & w_sel[c_OWN_D];
    assign w_xfer       = m_req & m_gnt;
    assign w_xfer_owner = w_sel[c_OWN_D] ? c_OWN_D : c_OWN_I;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_sel[c_OWN_I] && !m_gnt) begin
                    w_state_nxt = LOCK_I;
                end else if (w_sel[c_OWN_D] && !m_gnt) begin
                    w_state_nxt = LOCK_D;
                end
            end
            // A lock ends on the grant or when its owner abandons the request.
            LOCK_I:  if (m_gnt || !i_req) w_state_nxt = IDLE;
            LOCK_D:  if (m_gnt || !d_req) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_oth_req = (c_TIE_WIN == c_OWN_D) ? i_req : d_req;
    assign w_win_gnt = w_xfer && (w_xfer_owner == c_TIE_WIN);
    assign w_oth_gnt = w_xfer && (w_xfer_owner != c_TIE_WIN);

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_starve_cnt <= 4'd0;
        end else if (!w_oth_req || w_oth_gnt) begin
            r_starve_cnt <= 4'd0;
        end else if (w_win_gnt && (r_starve_cnt < c_MAX_BURST)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_rsp_vld   <= '0;
            r_rsp_owner <= c_OWN_I;
        end else begin
            r_rsp_vld <= w_xfer;
            if (w_xfer) begin
                r_rsp_owner <= w_xfer_owner;
            end
        end
    end

    // Response path is the only combinational route from m_rdata/m_error.
    assign w_rsp_i = r_rsp_vld[c_RSP_LATENCY-1] & ~g_reset & (r_rsp_owner == c_OWN_I);
    assign w_rsp_d = r_rsp_vld[c_RSP_LATENCY-1] & ~g_reset & (r_rsp_owner == c_OWN_D);

    assign i_error = m_error & w_rsp_i;
    assign d_error = m_error & w_rsp_d;
    assign i_rdata = w_rsp_i ? m_rdata : '0;
    assign d_rdata = w_rsp_d ? m_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_frv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_frv_mem_arbiter
// Description : Scoreboard bench for frv_mem_arbiter (D_PRIORITY=1,
//               MAX_BURST=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frv_mem_arbiter;

    localparam int          XLEN    = 32;
    localparam logic [31:0] c_IA    = 32'h8000_0000;
    localparam logic [31:0] c_DA    = 32'h0000_1000;
    localparam logic [31:0] c_DWD   = 32'h0000_ABCD;
    localparam logic [31:0] c_JUNK  = 32'hDEAD_BEEF;
    localparam logic [31:0] c_SBASE = 32'h5000_0000;

    logic            g_clk;
    logic            g_reset;
    logic            i_req, i_wen, i_gnt, i_error;
    logic [3:0]      i_strb;
    logic [XLEN-1:0] i_wdata, i_addr, i_rdata;
    logic            d_req, d_wen, d_gnt, d_error;
    logic [3:0]      d_strb;
    logic [XLEN-1:0] d_wdata, d_addr, d_rdata;
    logic            m_req, m_wen, m_gnt, m_error;
    logic [3:0]      m_strb;
    logic [XLEN-1:0] m_wdata, m_addr, m_rdata;

    typedef struct packed {
        logic [1:0]  gnts;
        logic [68:0] bus;
    } gnt_t;

    gnt_t        gnt_q[$];
    logic [65:0] rsp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    bit          pend     = 1'b0;

    frv_mem_arbiter #(
        .XLEN       (XLEN),
        .D_PRIORITY (1),
        .MAX_BURST  (4)
    ) dut (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .i_req   (i_req),
        .i_wen   (i_wen),
        .i_strb  (i_strb),
        .i_wdata (i_wdata),
        .i_addr  (i_addr),
        .i_gnt   (i_gnt),
        .i_error (i_error),
        .i_rdata (i_rdata),
        .d_req   (d_req),
        .d_wen   (d_wen),
        .d_strb  (d_strb),
        .d_wdata (d_wdata),
        .d_addr  (d_addr),
        .d_gnt   (d_gnt),
        .d_error (d_error),
        .d_rdata (d_rdata),
        .m_req   (m_req),
        .m_wen   (m_wen),
        .m_strb  (m_strb),
        .m_wdata (m_wdata),
        .m_addr  (m_addr),
        .m_gnt   (m_gnt),
        .m_error (m_error),
        .m_rdata (m_rdata)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge g_clk);
        #1;
    endtask

    task automatic set_in(input bit ir, input bit dr, input bit gnt,
                          input logic [31:0] rd, input bit err);
        i_req   = ir;
        d_req   = dr;
        m_gnt   = gnt;
        m_rdata = rd;
        m_error = err;
    endtask

    // Expect one transfer this cycle and its response next cycle.
    task automatic push_xfer(input bit own_d, input logic [31:0] rd, input bit err, input bit fwd);
        gnt_t g;
        g.gnts = own_d ? 2'b01 : 2'b10;
        g.bus  = own_d ? {1'b1, 4'b0011, c_DWD, c_DA} : {1'b0, 4'hF, 32'h0, c_IA};
        gnt_q.push_back(g);
        if (!fwd)       rsp_q.push_back(66'h0);
        else if (own_d) rsp_q.push_back({1'b0, err, 32'h0, rd});
        else            rsp_q.push_back({err, 1'b0, rd, 32'h0});
    endtask

    // Monitor: compares grants and responses whenever the DUT presents them.
    always @(negedge g_clk) begin
        if (pend) begin
            if (rsp_q.size() == 0) begin
                check("rsp_queue_underflow", 160'd1, 160'd0);
            end else begin
                check("rsp", {i_error, d_error, i_rdata, d_rdata}, rsp_q.pop_front());
            end
        end else begin
            check("idle_rsp", {i_error, d_error, i_rdata, d_rdata}, 160'h0);
        end
        pend = 1'b0;
        if (i_gnt || d_gnt) begin
            if (gnt_q.size() == 0) begin
                check("unexpected_gnt", {i_gnt, d_gnt, m_addr}, 160'h0);
            end else begin
                gnt_t e;
                e = gnt_q.pop_front();
                check("gnt_owner", {i_gnt, d_gnt}, e.gnts);
                check("gnt_bus", {m_req, m_wen, m_strb, m_wdata, m_addr}, {1'b1, e.bus});
            end
            pend = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_wen = 1'b0; i_strb = 4'hF;    i_wdata = 32'h0; i_addr = c_IA;
        d_wen = 1'b1; d_strb = 4'b0011; d_wdata = c_DWD; d_addr = c_DA;

        // Reset with both requesting and a noisy slave: everything must be 0.
        g_reset = 1'b1;
        set_in(1, 1, 1, c_JUNK, 1);
        repeat (2) begin
            @(negedge g_clk);
            check("reset_outs", {i_gnt, i_error, i_rdata, d_gnt, d_error, d_rdata,
                                 m_req, m_wen, m_strb, m_wdata, m_addr}, 160'h0);
            step();
        end
        g_reset = 1'b0;
        set_in(1, 1, 0, c_JUNK, 0);
        @(negedge g_clk);
        check("post_reset_sel", {m_req, m_addr}, {1'b1, c_DA});
        step();
        set_in(1, 1, 1, c_JUNK, 0); push_xfer(1, 32'h0000_1111, 0, 1); step();
        set_in(0, 0, 0, 32'h0000_1111, 0); step();

        // Single fetch.
        set_in(1, 0, 1, c_JUNK, 0); push_xfer(0, 32'h0000_0013, 0, 1); step();
        set_in(0, 0, 0, 32'h0000_0013, 0); step();

        // Tie: dmem wins.
        set_in(1, 1, 1, c_JUNK, 0); push_xfer(1, 32'hCAFE_0001, 0, 1); step();
        set_in(0, 0, 0, 32'hCAFE_0001, 0); step();

        // Lock on imem; dmem arriving mid-lock must not preempt.
        set_in(1, 0, 0, c_JUNK, 0);
        for (int k = 0; k < 3; k++) begin
            if (k == 1) d_req = 1'b1;
            @(negedge g_clk);
            check("lock_addr", {m_req, m_addr}, {1'b1, c_IA});
            step();
        end
        set_in(1, 1, 1, c_JUNK, 0); push_xfer(0, 32'h1111_0000, 0, 1); step();
        set_in(1, 1, 1, 32'h1111_0000, 0); push_xfer(1, 32'h2222_0000, 0, 1); step();
        set_in(0, 0, 0, 32'h2222_0000, 0); step();

        // Starvation: D,D,D,D,I,D,D,D,D,I; two responses carry errors.
        for (int k = 0; k <= 10; k++) begin
            set_in(k < 10, k < 10, k < 10,
                   (k > 0) ? c_SBASE + 32'(k - 1) : c_JUNK, (k == 3) || (k == 5));
            if (k < 10) push_xfer(!(k == 4 || k == 9), c_SBASE + 32'(k), (k == 2) || (k == 4), 1);
            step();
        end

        // Abort in LOCK_D: no transfer, lock released, imem then served.
        set_in(0, 1, 0, c_JUNK, 0); step();
        set_in(1, 0, 0, c_JUNK, 0);
        @(negedge g_clk);
        check("abort_mreq", {m_req, d_gnt, i_gnt}, 160'h0);
        step();
        set_in(1, 0, 1, c_JUNK, 0); push_xfer(0, 32'h0000_0077, 0, 1); step();
        set_in(0, 0, 0, 32'h0000_0077, 0); step();

        // Reset while a dmem error response is due: it must not be forwarded.
        set_in(0, 1, 1, c_JUNK, 0); push_xfer(1, 32'h0, 0, 0); step();
        g_reset = 1'b1;
        set_in(0, 0, 0, 32'hBAD0_BAD0, 1); step();
        g_reset = 1'b0;
        set_in(0, 0, 0, c_JUNK, 0); step();
        step();

        @(negedge g_clk);
        check("gnt_q_empty", 160'(gnt_q.size()), 160'd0);
        check("rsp_q_empty", 160'(rsp_q.size()), 160'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frv_mem_arbiter.md
Name: frv_mem_arbiter

Overview:
- Shares one external memory port between the core's instruction fetch (imem) and load/store (dmem) request/grant interfaces.
- Sits between the core top and a single-ported SRAM or bus bridge.
- Provides priority arbitration, request locking until grant, response routing, and starvation protection so that fetch always progresses.

Parameters:
- XLEN, 32, data and address width.
- D_PRIORITY, 1, 1 = dmem wins ties, 0 = imem wins ties.
- MAX_BURST, 4, consecutive grants the tie-winner may take while the other side waits (1..15).

Ports:
- g_clk  in  1  global clock
- g_reset  in  1  synchronous reset, active-high
- i_req  in  1  imem request
- i_wen  in  1  imem write enable
- i_strb  in  4  imem byte strobe
- i_wdata  in  XLEN  imem write data
- i_addr  in  XLEN  imem address
- i_gnt  out  1  imem request accepted
- i_error  out  1  imem response error
- i_rdata  out  XLEN  imem read data
- d_req, d_wen, d_strb, d_wdata, d_addr, d_gnt, d_error, d_rdata: same as the i_ set, for dmem
- m_req  out  1  shared-port request
- m_wen  out  1  shared-port write enable
- m_strb  out  4  shared-port strobe
- m_wdata  out  XLEN  shared-port write data
- m_addr  out  XLEN  shared-port address
- m_gnt  in  1  shared-port accept
- m_error  in  1  shared-port error, valid in the cycle after the accept
- m_rdata  in  XLEN  shared-port read data, valid in the cycle after the accept

Behaviour:
- Protocol
  - Request transfers when req & gnt.
  - Response (rdata/error) is valid exactly one cycle after the transfer.
  - One request is outstanding per transfer; back-to-back transfers are allowed.
- FSM states: IDLE, LOCK_I, LOCK_D. Reset state is IDLE.
- Select rule
  - IDLE: select is combinational from the priority rule.
  - LOCK_I / LOCK_D: select is fixed to I or D respectively.
- IDLE transitions
  - If the selected requester is not granted, go to LOCK_x.
  - If it is granted, stay in IDLE, so the next request re-arbitrates the following cycle.
- LOCK_x transitions
  - m_gnt -> IDLE.
  - Locked requester drops req without a grant (abort) -> IDLE, no transfer.
  - The other requester never preempts a lock.
- Priority rule in IDLE
  - Only one requester active: that one wins.
  - Both active: the D_PRIORITY side wins, unless starve_cnt == MAX_BURST, in which case the other side wins.
- starve_cnt (4-bit, reset 0)
  - Increments (saturating at MAX_BURST) on each tie-winner grant while the other side's req is high.
  - Clears on any grant to the other side, or in any cycle where the other side's req is low.
- Output muxing
  - m_req/m_wen/m_strb/m_wdata/m_addr are the selected requester's signals.
  - All zero when nothing is selected.
  - i_gnt = m_gnt & sel_i; d_gnt = m_gnt & sel_d.
- Response routing
  - rsp_vld and rsp_owner registers are set on a transfer and cleared the next cycle unless another transfer occurs.
  - i_error = m_error & rsp_vld & owner==I; likewise for d_error.
  - i_rdata / d_rdata = m_rdata when the owner matches and rsp_vld is set, else 0.
- Reset values: all outputs 0, FSM IDLE, rsp_vld 0, starve_cnt 0.
- Reset mid-lock or with a response pending: the request is dropped and the response is not forwarded.
- Response data is forwarded in the same cycle it arrives; no other combinational path exists from m_rdata.

Decomposition:
- Shared package frv_mem_pkg holds:
  - state enum (IDLE, LOCK_I, LOCK_D)
  - owner encoding (OWN_I=0, OWN_D=1)
  - the req/gnt/rsp latency constant (1)
- One natural sub-module: frv_mem_arb_prio, which takes both reqs, D_PRIORITY and starve_cnt and produces a one-hot select.

Test Plan:
- Reset: assert g_reset with i_req=d_req=1 -> all outputs 0; one cycle after deassertion, m_req=1 with d_addr forwarded (D_PRIORITY=1).
- Single fetch: i_req=1, i_addr=0x80000000, m_gnt=1 -> i_gnt=1 the same cycle; next cycle m_rdata=0x00000013 appears on i_rdata, d_rdata=0, d_error=0.
- Tie: both requesters active with m_gnt=1 -> d_gnt=1, i_gnt=0; i_rdata stays 0 during the dmem response.
- Lock: imem alone, m_gnt=0 for 3 cycles, d_req rises in cycle 2 -> m_addr holds i_addr for all 3 cycles; gnt goes to imem; dmem wins in the next cycle.
- Starvation (MAX_BURST=4): d_req and i_req held high, m_gnt=1 every cycle -> grants D,D,D,D,I,D,D,D,D,I.
- Abort and reset: in LOCK_D, d_req drops -> IDLE with no transfer and no d_gnt. Separately, g_reset asserted the cycle after a transfer with m_error=1 -> d_error stays 0.
